pe_stencil_sequencer: RTL and testbench
=======================================

// Module: pe_stencil_sequencer
// PURPOSE
//  Upstream driver for one bit-serial PDE processing element (PE). Takes one parallel
//  stencil (left/top/right/down neighbour values) per iteration over a valid/ready
//  handshake. Shifts the four values into the PE MSB-first with pe_mode=1, then strobes
//  the PE latch, runs the PE compute window with pe_mode=0, and strobes the PE update.
//  Replaces hand-sequenced mode/strobe stimulus with a single-clock sequencer.
// PARAMETERS
//  WIDTH          8  bits per neighbour value; also the number of LOAD cycles
//  COMPUTE_CYCLES 8  clka cycles held in COMPUTE with pe_mode=0 (>=1)
// PORTS
//  clka        in   1      sole clock; all state updates on the rising edge
//  rst_n       in   1      asynchronous active-low reset
//  in_valid    in   1      stencil word valid
//  in_ready    out  1      sequencer can accept a stencil (combinational: state==IDLE)
//  in_left     in   WIDTH  left neighbour value
//  in_top      in   WIDTH  top neighbour value
//  in_right    in   WIDTH  right neighbour value
//  in_down     in   WIDTH  down neighbour value
//  pe_mode     out  1      1 = PE shift-in/latch phase, 0 = PE compute phase
//  pe_left     out  1      serial left bit to the PE
//  pe_top      out  1      serial top bit to the PE
//  pe_right    out  1      serial right bit to the PE
//  pe_down     out  1      serial down bit to the PE
//  pe_commit   out  1      one-cycle strobe; the PE registers its phase result
//  busy        out  1      1 in any state other than IDLE
//  done        out  1      one-cycle pulse in UPDATE; the iteration is complete
// BEHAVIOUR
//  - States: IDLE -> LOAD (WIDTH cycles) -> LATCH (1) -> COMPUTE (COMPUTE_CYCLES) -> UPDATE (1) -> IDLE.
//  - Accept: in_valid & in_ready at edge E. The four words go into shift registers and the state becomes LOAD.
//  - in_valid is ignored while in_ready=0; nothing is queued.
//  - LOAD: pe_mode=1. pe_* are the MSBs of the shift registers, so cycle k (k=0..WIDTH-1)
//    presents bit WIDTH-1-k. Each shift register shifts left, zero-filling, every LOAD cycle.
//  - A bit counter (width $clog2(WIDTH)) runs from 0 to WIDTH-1. LOAD exits after the cycle where the count is WIDTH-1.
//  - LATCH: pe_mode=1, pe_commit=1, pe_* = 0.
//  - COMPUTE: pe_mode=0, pe_* = 0. The counter runs from 0 to COMPUTE_CYCLES-1, then the state moves to UPDATE.
//  - UPDATE: pe_mode=0, pe_commit=1, done=1. The next state is always IDLE.
//  - in_ready returns in the following cycle, so there is no accept in the UPDATE cycle.
//  - Latency from accept edge E:
//      LOAD          E+1 .. E+WIDTH
//      LATCH         E+WIDTH+1
//      COMPUTE       E+WIDTH+2 .. E+WIDTH+1+COMPUTE_CYCLES
//      UPDATE        E+WIDTH+2+COMPUTE_CYCLES
//      in_ready=1    one cycle later
//  - Defaults: 19 cycles from accept to in_ready, i.e. one stencil per 19 cycles.
//  - Reset (asynchronous, any state, including mid-LOAD or mid-COMPUTE):
//      state=IDLE; shift registers and counter = 0
//      pe_mode, pe_*, pe_commit, busy, done = 0; in_ready=1
//      the in-flight stencil is dropped and no done is issued for it
//  - Release of rst_n while in_valid=1: accept happens on the first rising edge with rst_n high.
//  - All outputs except in_ready are registered or decoded from state/shift registers only. There is no combinational path from in_*.
// CONFIGURATION
//  - ITER_COUNT_EN defined:
//      adds output iter_cnt [15:0], reset to 0
//      iter_cnt increments on each UPDATE cycle and wraps 16'hFFFF -> 0
//      iter_cnt is cleared by rst_n only
//  - ITER_COUNT_EN undefined: the port and the counter do not exist; all other behaviour is identical.
// TESTING
//  1. Reset: hold rst_n=0 with in_valid=1 -> in_ready=1, busy=0, pe_mode=0, pe_commit=0, done=0.
//  2. Single stencil, all words 8'h40, accept at E:
//       E+1..E+8: pe_left=pe_top=pe_right=pe_down = 0,1,0,0,0,0,0,0 with pe_mode=1
//       E+9: pe_commit=1, pe_mode=1
//       E+10..E+17: pe_mode=0
//       E+18: pe_commit=1, done=1
//       E+19: in_ready=1
//  3. Distinct words left=E4 top=E7 right=B0 down=CC -> serial streams
//       left  1110_0100
//       top   1110_0111
//       right 1011_0000
//       down  1100_1100
//     Check every bit, MSB first.
//  4. Back-to-back: in_valid held 1 with two stencils -> second accept exactly 19 cycles
//     after the first; words changing during busy are ignored (second stencil sampled at its accept).
//  5. Reset mid-LOAD: rst_n=0 after 3 LOAD cycles -> immediate IDLE outputs, no done.
//     A new stencil after release is serialized from its MSB.
//  6. ITER_COUNT_EN: 3 iterations -> iter_cnt = 1,2,3, each step one cycle after its done.
//     Force iter_cnt=16'hFFFF, run one iteration -> 0.

Source files
------------

// File: rtl/pe_stencil_sequencer.sv
// pe_stencil_sequencer
//   Upstream driver for one bit-serial PDE processing element. Accepts one
//   stencil (left/top/right/down words) over valid/ready. It shifts the words
//   into the PE MSB-first with pe_mode=1 and strobes the PE latch. It then
//   holds the compute window with pe_mode=0 and strobes the PE update.
//
//   Optional feature macro: ITER_COUNT_EN adds a 16-bit completed-iteration
//   counter on output iter_cnt.
//
// Ports
//   clka                 sole clock, rising edge
//   rst_n                asynchronous active-low reset
//   in_valid / in_ready  stencil handshake (in_ready = state is IDLE)
//   in_left/top/right/down  WIDTH-bit neighbour values
//   pe_mode              1 = shift-in/latch phase, 0 = compute phase
//   pe_left/top/right/down  serial neighbour bits to the PE
//   pe_commit            one-cycle PE register strobe (LATCH and UPDATE)
//   busy                 sequencer not in IDLE
//   done                 one-cycle pulse in UPDATE
//   iter_cnt             [ITER_COUNT_EN only] completed iterations, wraps
module pe_stencil_sequencer #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned COMPUTE_CYCLES = 8
) (
  input  logic             clka,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_left,
  input  logic [WIDTH-1:0] in_top,
  input  logic [WIDTH-1:0] in_right,
  input  logic [WIDTH-1:0] in_down,
  output logic             pe_mode,
  output logic             pe_left,
  output logic             pe_top,
  output logic             pe_right,
  output logic             pe_down,
  output logic             pe_commit,
  output logic             busy,
  output logic             done
`ifdef ITER_COUNT_EN
  ,
  output logic [15:0]      iter_cnt
`endif
);

  localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned CMP_W = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;
  localparam int unsigned CNT_W = (BIT_W > CMP_W) ? BIT_W : CMP_W;
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CMP_LAST  = CNT_W'(COMPUTE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LATCH,
    S_COMPUTE,
    S_UPDATE
  } state_e;

  // Index 0..3 = left, top, right, down
  logic [3:0][WIDTH-1:0] sh_q, sh_d;
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  mode_q, mode_d;
  logic                  commit_q, commit_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
`ifdef ITER_COUNT_EN
  logic [15:0]           iter_cnt_q;
`endif

  // Next state, shift/counter update, and output decode of the next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sh_d    = {in_down, in_right, in_top, in_left};
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        // Zero-fill leaves the registers clear once the word is shifted out,
        // so the serial outputs read 0 outside LOAD with no extra gating.
        for (int i = 0; i < 4; i++) sh_d[i] = sh_q[i] << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LOAD_LAST) begin
          cnt_d   = '0;
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        cnt_d   = '0;
        state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CMP_LAST) begin
          cnt_d   = '0;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    mode_d   = (state_d == S_LOAD) || (state_d == S_LATCH);
    commit_d = (state_d == S_LATCH) || (state_d == S_UPDATE);
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_UPDATE);
  end

  // State and output registers
  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sh_q       <= '0;
      mode_q     <= 1'b0;
      commit_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef ITER_COUNT_EN
      iter_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      mode_q     <= mode_d;
      commit_q   <= commit_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef ITER_COUNT_EN
      if (state_q == S_UPDATE) iter_cnt_q <= iter_cnt_q + 16'd1;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign pe_mode   = mode_q;
  assign pe_commit = commit_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pe_left   = sh_q[0][WIDTH-1];
  assign pe_top    = sh_q[1][WIDTH-1];
  assign pe_right  = sh_q[2][WIDTH-1];
  assign pe_down   = sh_q[3][WIDTH-1];
`ifdef ITER_COUNT_EN
  assign iter_cnt  = iter_cnt_q;
`endif

endmodule

// File: tb/tb_pe_stencil_sequencer.sv
// Testbench for pe_stencil_sequencer: random and directed stencils checked
// cycle by cycle against a timeline model of one iteration.
module tb_pe_stencil_sequencer;

  localparam int W = 8;
  localparam int C = 8;
  localparam int P = W + C + 3;  // accept edge to in_ready=1, in cycles

  logic         clka = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_left, in_top, in_right, in_down;
  logic         pe_mode, pe_left, pe_top, pe_right, pe_down;
  logic         pe_commit, busy, done;
`ifdef ITER_COUNT_EN
  logic [15:0]  iter_cnt;
  logic [15:0]  exp_iter = 16'd0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clka = ~clka;

  pe_stencil_sequencer #(.WIDTH(W), .COMPUTE_CYCLES(C)) dut (
    .clka      (clka),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_left   (in_left),
    .in_top    (in_top),
    .in_right  (in_right),
    .in_down   (in_down),
    .pe_mode   (pe_mode),
    .pe_left   (pe_left),
    .pe_top    (pe_top),
    .pe_right  (pe_right),
    .pe_down   (pe_down),
    .pe_commit (pe_commit),
    .busy      (busy),
    .done      (done)
`ifdef ITER_COUNT_EN
    ,
    .iter_cnt  (iter_cnt)
`endif
  );

  // {in_ready, busy, pe_mode, pe_commit, done, pe_left, pe_top, pe_right, pe_down}
  logic [8:0] obs;
  assign obs = {in_ready, busy, pe_mode, pe_commit, done, pe_left, pe_top, pe_right, pe_down};

  // Expected outputs in cycle L after the accept edge (L<=0 or L>=P: idle).
  function automatic logic [8:0] model(input int L, input logic [W-1:0] l, input logic [W-1:0] t,
                                       input logic [W-1:0] r, input logic [W-1:0] d);
    logic [8:0] v;
    int idx;
    v = '0;
    if (L >= 1 && L <= W) begin
      idx  = W - L;
      v[7] = 1'b1;
      v[6] = 1'b1;
      v[3] = l[idx];
      v[2] = t[idx];
      v[1] = r[idx];
      v[0] = d[idx];
    end else if (L == W + 1) begin
      v[7] = 1'b1; v[6] = 1'b1; v[5] = 1'b1;
    end else if (L >= W + 2 && L <= W + 1 + C) begin
      v[7] = 1'b1;
    end else if (L == W + 2 + C) begin
      v[7] = 1'b1; v[5] = 1'b1; v[4] = 1'b1;
    end else begin
      v[8] = 1'b1;
    end
    return v;
  endfunction

  function automatic logic [W-1:0] rnd();
    return W'($urandom);
  endfunction

  // Offer one stencil at the coming edge and check cycles 1..stop after it.
  task automatic run_iter(input string name, input logic [W-1:0] l, input logic [W-1:0] t,
                          input logic [W-1:0] r, input logic [W-1:0] d,
                          input bit hold, input bit scramble, input int stop);
    logic [8:0] e;
    in_left = l; in_top = t; in_right = r; in_down = d;
    in_valid = 1'b1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s ready-before-accept got %b want 1", name, in_ready);
    end
    for (int L = 1; L <= stop; L++) begin
      @(posedge clka);
      @(negedge clka);
      e = model(L, l, t, r, d);
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL %s cycle %0d got %b want %b", name, L, obs, e);
      end
`ifdef ITER_COUNT_EN
      if (L == P - 1 || L == P) begin
        if (L == P) exp_iter = exp_iter + 16'd1;
        n_cmp++;
        if (iter_cnt !== exp_iter) begin
          n_bad++;
          $display("FAIL %s iter_cnt cycle %0d got %h want %h", name, L, iter_cnt, exp_iter);
        end
      end
`endif
      if (!hold) in_valid = 1'b0;
      if (scramble && L < P) begin
        in_left = rnd(); in_top = rnd(); in_right = rnd(); in_down = rnd();
      end
    end
  endtask

  // Idle cycles with in_valid low and garbage on the data inputs.
  task automatic idle_cycles(input string name, input int n);
    logic [8:0] e;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      in_left = rnd(); in_top = rnd(); in_right = rnd(); in_down = rnd();
      @(posedge clka);
      @(negedge clka);
      e = model(0, '0, '0, '0, '0);
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL %s idle %0d got %b want %b", name, i, obs, e);
      end
    end
  endtask

  task automatic test_reset();
    logic [8:0] e;
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_left = rnd(); in_top = rnd(); in_right = rnd(); in_down = rnd();
    e = model(0, '0, '0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clka);
      @(negedge clka);
      n_cmp++;
      if (obs !== e) begin
        n_bad++;
        $display("FAIL reset cycle %0d got %b want %b", i, obs, e);
      end
    end
  endtask

  // Release reset with in_valid already high: accept on the first edge.
  task automatic test_single();
    rst_n = 1'b1;
    run_iter("single_40", 8'h40, 8'h40, 8'h40, 8'h40, 1'b0, 1'b0, P);
  endtask

  task automatic test_distinct();
    idle_cycles("distinct_gap", 1);
    run_iter("distinct", 8'hE4, 8'hE7, 8'hB0, 8'hCC, 1'b0, 1'b0, P);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      idle_cycles("random_gap", int'($urandom_range(0, 3)));
      run_iter("random", rnd(), rnd(), rnd(), rnd(), 1'b0, 1'b1, P);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++)
      run_iter("b2b", rnd(), rnd(), rnd(), rnd(), 1'b1, 1'b1, P);
    idle_cycles("b2b_tail", 2);
  endtask

  task automatic test_reset_mid_load();
    logic [8:0] e;
    run_iter("midload_pre", rnd(), rnd(), rnd(), rnd(), 1'b0, 1'b0, 3);
    #2 rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    e = model(0, '0, '0, '0, '0);
    n_cmp++;
    if (obs !== e) begin
      n_bad++;
      $display("FAIL midload_async got %b want %b", obs, e);
    end
`ifdef ITER_COUNT_EN
    exp_iter = 16'd0;
`endif
    idle_cycles("midload_held", 2);
    rst_n = 1'b1;
    idle_cycles("midload_after", 2);
    run_iter("midload_post", rnd(), rnd(), rnd(), rnd(), 1'b0, 1'b0, P);
  endtask

`ifdef ITER_COUNT_EN
  task automatic test_iter_count();
    for (int k = 0; k < 3; k++)
      run_iter("iter", rnd(), rnd(), rnd(), rnd(), 1'b0, 1'b0, P);
    force dut.iter_cnt_q = 16'hFFFF;
    #1 release dut.iter_cnt_q;
    exp_iter = 16'hFFFF;
    run_iter("iter_wrap", rnd(), rnd(), rnd(), rnd(), 1'b0, 1'b0, P);
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_distinct();
    test_random();
    test_back_to_back();
    test_reset_mid_load();
`ifdef ITER_COUNT_EN
    test_iter_count();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
